systolic_ctrl: RTL
==================

SYSTOLIC_CTRL -- requirements
Module: systolic_ctrl

Interface
REQ-001 SHALL have parameter DATAWIDTH, 16, operand element width in bits.
REQ-002 SHALL have parameter N_SIZE, 5, matrix dimension; array is N_SIZE x N_SIZE.
REQ-003 SHALL have parameter TIMEOUT, 4*N_SIZE, maximum cycles spent in DRAIN before abort.
REQ-004 SHALL have port clk  in  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port rst  in  1  synchronous active-high reset.
REQ-006 SHALL have ports start in 1 (job request pulse), busy out 1 (job in progress), done out 1 (one-cycle completion pulse), err out 1 (one-cycle timeout pulse).
REQ-007 SHALL have ports in_valid in 1, in_ready out 1, in_a in N_SIZE*DATAWIDTH (column k of A), in_b in N_SIZE*DATAWIDTH (row k of B).
REQ-008 SHALL have ports arr_valid_in out 1, arr_a out N_SIZE*DATAWIDTH, arr_b out N_SIZE*DATAWIDTH, driving the array inputs.
REQ-009 SHALL have ports arr_valid_out in 1, arr_c in N_SIZE*2*DATAWIDTH, receiving array result rows.
REQ-010 SHALL have ports out_valid out 1, out_ready in 1, out_c out N_SIZE*2*DATAWIDTH, out_row out $clog2(N_SIZE), out_last out 1.

Function
REQ-011 SHALL implement FSM IDLE -> FILL -> FEED -> DRAIN -> EMIT -> IDLE.
REQ-012 IDLE: start=1 -> FILL next cycle; busy=0; start ignored in every other state.
REQ-013 FILL: in_ready=1; each in_valid&in_ready beat stores (in_a,in_b) at index k (0..N_SIZE-1); after beat N_SIZE-1 -> FEED; gaps in in_valid tolerated.
REQ-014 FEED: arr_valid_in=1 for exactly N_SIZE consecutive cycles presenting beats 0..N_SIZE-1 in order; then -> DRAIN.
REQ-015 arr_valid_in SHALL be 0 and arr_a/arr_b SHALL be 0 in every state except FEED.
REQ-016 DRAIN: each cycle with arr_valid_out=1 captures arr_c into result row r (0..N_SIZE-1); after row N_SIZE-1 -> EMIT.
REQ-017 DRAIN cycle counter SHALL reach TIMEOUT without N_SIZE rows -> err=1 for one cycle, -> IDLE, no done.
REQ-018 arr_valid_out outside DRAIN, or beyond N_SIZE rows, SHALL be ignored.
REQ-019 EMIT: out_valid=1, out_c=row r, out_row=r, out_last=(r==N_SIZE-1); r advances only on out_valid&out_ready.
REQ-020 out_c/out_row/out_last SHALL stay stable while out_valid=1 and out_ready=0.
REQ-021 Final handshake (out_last) -> IDLE and done=1 in that IDLE cycle; start in that same cycle SHALL be accepted.
REQ-022 busy SHALL be 1 in FILL, FEED, DRAIN, EMIT.
REQ-023 Result storage SHALL be 2*DATAWIDTH per element, no truncation.

Reset
REQ-024 rst=1 SHALL force, next edge: state IDLE, all counters 0, busy/done/err/in_ready/out_valid/out_last/arr_valid_in 0, out_row 0.
REQ-025 Reset mid-job (any state) SHALL discard buffered operands/results; no done or err pulse.
REQ-026 Buffer contents need not be reset; only outputs listed in REQ-024 are defined.

Structure
REQ-027 systolic_pkg SHALL hold the state enum (IDLE,FILL,FEED,DRAIN,EMIT) and default DATAWIDTH/N_SIZE constants.
REQ-028 Sub-module systolic_row_buf (N_SIZE-entry register buffer, indexed write/read, parameterized width) SHALL be instantiated for the operand buffer and the result buffer.

Verification (A = rows 1..5,6..10,..,21..25; B = rows 26..30,..,46..50; array model latency 2*N_SIZE-1)
REQ-029 Full job, in_valid continuous, out_ready=1 -> out_row0 = 590 605 620 635 650, out_row4 = 4190 4305 4420 4535 4650, out_last on row4, done one cycle later.
REQ-030 in_valid deasserted 3 cycles between beats 1 and 2 -> arr_valid_in still 5 consecutive cycles, same results as REQ-029.
REQ-031 out_ready=0 for 10 cycles at row 2 -> out_c holds row 2 stable, all 5 rows delivered once in order.
REQ-032 start pulsed during FEED -> ignored; start in done cycle -> second job runs, identical results.
REQ-033 rst during FEED cycle 2 -> arr_valid_in=0 and busy=0 next cycle, no done/err; new job afterwards correct.
REQ-034 array model never asserts arr_valid_out -> err=1 exactly TIMEOUT (20) cycles after DRAIN entry, busy=0 after.

Source files
------------

// File: rtl/systolic_pkg.sv
// systolic_pkg: shared state encoding and default sizing for the systolic array controller.
package systolic_pkg;
    localparam int DEF_DATAWIDTH = 16;
    localparam int DEF_N_SIZE    = 5;
    typedef enum logic [2:0] {IDLE, FILL, FEED, DRAIN, EMIT} state_t;
endpackage

// File: rtl/systolic_row_buf.sv
// systolic_row_buf: DEPTH-entry register buffer with indexed write and combinational indexed read.
module systolic_row_buf #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 5
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);
    logic [WIDTH-1:0] mem [DEPTH];
    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;
    assign rdata = mem[raddr];
endmodule

// File: rtl/systolic_ctrl.sv
// systolic_ctrl: loads operand beats, feeds them to an N_SIZE x N_SIZE systolic array,
// collects the result rows and hands them out one row per handshake.
module systolic_ctrl
    import systolic_pkg::*;
#(
    parameter int DATAWIDTH = DEF_DATAWIDTH,
    parameter int N_SIZE    = DEF_N_SIZE,
    parameter int TIMEOUT   = 4 * N_SIZE
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    output logic                            busy,
    output logic                            done,
    output logic                            err,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [N_SIZE*DATAWIDTH-1:0]     in_a,
    input  logic [N_SIZE*DATAWIDTH-1:0]     in_b,
    output logic                            arr_valid_in,
    output logic [N_SIZE*DATAWIDTH-1:0]     arr_a,
    output logic [N_SIZE*DATAWIDTH-1:0]     arr_b,
    input  logic                            arr_valid_out,
    input  logic [N_SIZE*2*DATAWIDTH-1:0]   arr_c,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [N_SIZE*2*DATAWIDTH-1:0]   out_c,
    output logic [$clog2(N_SIZE)-1:0]       out_row,
    output logic                            out_last
);
    localparam int CW = $clog2(N_SIZE);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int RW = 2 * N_SIZE * DATAWIDTH;
    localparam logic [CW-1:0] LAST = CW'(N_SIZE - 1);
    state_t        state;
    logic [CW-1:0] k, r;
    logic [TW-1:0] drain_cnt;
    logic [RW-1:0] op, res;
    logic          wr_op, wr_res, last_k, last_r;
    assign last_k       = k == LAST;
    assign last_r       = r == LAST;
    assign wr_op        = state == FILL && in_valid;
    assign wr_res       = state == DRAIN && arr_valid_out;
    assign busy         = state != IDLE;
    assign in_ready     = state == FILL;
    assign arr_valid_in = state == FEED;
    assign {arr_a, arr_b} = arr_valid_in ? op : '0;
    assign out_valid    = state == EMIT;
    assign out_c        = res;
    assign out_row      = r;
    assign out_last     = out_valid && last_r;
    // operand entry k holds {column k of A, row k of B}
    systolic_row_buf #(.WIDTH(RW), .DEPTH(N_SIZE)) u_op_buf (
        .clk(clk), .we(wr_op), .waddr(k), .wdata({in_a, in_b}), .raddr(k), .rdata(op)
    );
    systolic_row_buf #(.WIDTH(RW), .DEPTH(N_SIZE)) u_res_buf (
        .clk(clk), .we(wr_res), .waddr(r), .wdata(arr_c), .raddr(r), .rdata(res)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            k         <= '0;
            r         <= '0;
            drain_cnt <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: if (start) state <= FILL;
                FILL: if (in_valid) begin
                    k <= last_k ? '0 : k + 1'b1;
                    if (last_k) state <= FEED;
                end
                FEED: begin
                    k <= last_k ? '0 : k + 1'b1;
                    if (last_k) state <= DRAIN;
                end
                DRAIN: begin
                    drain_cnt <= drain_cnt + 1'b1;
                    if (arr_valid_out) r <= last_r ? '0 : r + 1'b1;
                    // a completed final row wins over a timeout in the same cycle
                    if (arr_valid_out && last_r) begin
                        state     <= EMIT;
                        drain_cnt <= '0;
                    end else if (drain_cnt == TW'(TIMEOUT - 1)) begin
                        state     <= IDLE;
                        err       <= 1'b1;
                        drain_cnt <= '0;
                        r         <= '0;
                    end
                end
                EMIT: if (out_ready) begin
                    r <= last_r ? '0 : r + 1'b1;
                    if (last_r) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
